// File: rtl/vector_stream_driver.sv
// vector_stream_driver
// Initiator side of the vector compute handshake. Collects eight (a, b)
// element pairs from a valid/ready stream into flat 64-bit operand vectors,
// fires a one-cycle start pulse at the compute host, waits (with a watchdog)
// for the host's done pulse, captures the 128-bit result and streams it out
// as eight 16-bit elements with valid/ready and a last flag.
//
// Ports:
//   clk, rst            clock (rising edge) and async active-high reset
//   in_valid/in_ready   element-pair input handshake
//   in_a, in_b, in_op   element pair; in_op is sampled with element 0 only
//   vector_a_flat/_b    packed operand vectors, element i at [8i+7:8i]
//   vector_op           operation latched from element 0
//   compute_enable      one-cycle start pulse to the host
//   compute_done        host completion pulse (only honoured while waiting)
//   vector_result_flat  host result, element i at [16i+15:16i]
//   out_valid/out_ready result element handshake
//   out_data, out_index result element and its index
//   out_last            high with index 7
//   busy                high unless idle with no partial vector loaded
//   timeout_err         one-cycle pulse when the watchdog aborts a wait
module vector_stream_driver #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_a,
   input  logic [7:0]   in_b,
   input  logic [2:0]   in_op,
   output logic [63:0]  vector_a_flat,
   output logic [63:0]  vector_b_flat,
   output logic [2:0]   vector_op,
   output logic         compute_enable,
   input  logic         compute_done,
   input  logic [127:0] vector_result_flat,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [15:0]  out_data,
   output logic [2:0]   out_index,
   output logic         out_last,
   output logic         busy,
   output logic         timeout_err
);

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t         state_r;
   state_t         state_s;
   logic [2:0]     cnt_r;
   logic [2:0]     cnt_s;
   logic [2:0]     idx_r;
   logic [2:0]     idx_s;
   logic [2:0]     idx_inc_s;
   logic [7:0]     wdog_r;
   logic [7:0]     wdog_s;
   logic [127:0]   result_r;
   logic [127:0]   result_s;
   logic [63:0]    a_flat_s;
   logic [63:0]    b_flat_s;
   logic [2:0]     op_s;
   logic [15:0]    out_data_s;
   logic           timeout_s;

   // The abort pulse must be suppressed by a same-cycle done, so it is a
   // decode of the current state and the live done input rather than a flop.
   assign timeout_err = timeout_s;

   // Next-state, datapath and counter update logic.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      idx_s      = idx_r;
      wdog_s     = wdog_r;
      result_s   = result_r;
      a_flat_s   = vector_a_flat;
      b_flat_s   = vector_b_flat;
      op_s       = vector_op;
      out_data_s = out_data;
      timeout_s  = 1'b0;
      idx_inc_s  = idx_r + 3'd1;

      case (state_r)
         ST_LOAD: begin
            // in_ready is high throughout LOAD, so in_valid alone is an accept.
            if (in_valid) begin
               a_flat_s[{cnt_r, 3'b000} +: 8] = in_a;
               b_flat_s[{cnt_r, 3'b000} +: 8] = in_b;
               if (cnt_r == 3'd0) begin
                  op_s = in_op;
               end else begin
                  op_s = vector_op;
               end
               cnt_s = cnt_r + 3'd1;
               if (cnt_r == 3'd7) begin
                  state_s = ST_ISSUE;
               end else begin
                  state_s = ST_LOAD;
               end
            end else begin
               cnt_s = cnt_r;
            end
         end

         ST_ISSUE: begin
            wdog_s  = 8'd0;
            state_s = ST_WAIT;
         end

         ST_WAIT: begin
            // Done has priority over the watchdog terminal count.
            if (compute_done) begin
               result_s   = vector_result_flat;
               out_data_s = vector_result_flat[15:0];
               idx_s      = 3'd0;
               wdog_s     = 8'd0;
               state_s    = ST_DRAIN;
            end else if (wdog_r == WDOG_LAST) begin
               timeout_s = 1'b1;
               wdog_s    = 8'd0;
               state_s   = ST_LOAD;
            end else begin
               wdog_s = wdog_r + 8'd1;
            end
         end

         ST_DRAIN: begin
            if (out_ready) begin
               idx_s = idx_inc_s;
               if (idx_r == 3'd7) begin
                  state_s = ST_LOAD;
               end else begin
                  // Preload the next element so out_data stays a register.
                  out_data_s = result_r[{idx_inc_s, 4'b0000} +: 16];
                  state_s    = ST_DRAIN;
               end
            end else begin
               idx_s = idx_r;
            end
         end

         default: begin
            state_s = ST_LOAD;
            cnt_s   = 3'd0;
            idx_s   = 3'd0;
            wdog_s  = 8'd0;
         end
      endcase
   end

   // State, counters, datapath and registered output flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r        <= ST_LOAD;
         cnt_r          <= 3'd0;
         idx_r          <= 3'd0;
         wdog_r         <= 8'd0;
         result_r       <= 128'd0;
         vector_a_flat  <= 64'd0;
         vector_b_flat  <= 64'd0;
         vector_op      <= 3'd0;
         in_ready       <= 1'b1;
         compute_enable <= 1'b0;
         out_valid      <= 1'b0;
         out_data       <= 16'd0;
         out_index      <= 3'd0;
         out_last       <= 1'b0;
         busy           <= 1'b0;
      end else begin
         state_r        <= state_s;
         cnt_r          <= cnt_s;
         idx_r          <= idx_s;
         wdog_r         <= wdog_s;
         result_r       <= result_s;
         vector_a_flat  <= a_flat_s;
         vector_b_flat  <= b_flat_s;
         vector_op      <= op_s;
         in_ready       <= (state_s == ST_LOAD);
         compute_enable <= (state_s == ST_ISSUE);
         out_valid      <= (state_s == ST_DRAIN);
         out_data       <= out_data_s;
         out_index      <= idx_s;
         out_last       <= (state_s == ST_DRAIN) && (idx_s == 3'd7);
         busy           <= !((state_s == ST_LOAD) && (cnt_s == 3'd0));
      end
   end

endmodule

// File: tb/tb_vector_stream_driver.sv
module tb_vector_stream_driver;

   localparam int TO = 64;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [7:0]   in_a;
   logic [7:0]   in_b;
   logic [2:0]   in_op;
   logic [63:0]  vector_a_flat;
   logic [63:0]  vector_b_flat;
   logic [2:0]   vector_op;
   logic         compute_enable;
   logic         compute_done;
   logic [127:0] vector_result_flat;
   logic         out_valid;
   logic         out_ready;
   logic [15:0]  out_data;
   logic [2:0]   out_index;
   logic         out_last;
   logic         busy;
   logic         timeout_err;

   vector_stream_driver #(.TIMEOUT_CYCLES(TO)) dut (
      .clk                (clk),
      .rst                (rst),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .in_a               (in_a),
      .in_b               (in_b),
      .in_op              (in_op),
      .vector_a_flat      (vector_a_flat),
      .vector_b_flat      (vector_b_flat),
      .vector_op          (vector_op),
      .compute_enable     (compute_enable),
      .compute_done       (compute_done),
      .vector_result_flat (vector_result_flat),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .out_data           (out_data),
      .out_index          (out_index),
      .out_last           (out_last),
      .busy               (busy),
      .timeout_err        (timeout_err)
   );

   always #5 clk = ~clk;

   // cyc == N during the cycle that follows rising edge N
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   // stimulus vector and host result
   logic [7:0]  va [8];
   logic [7:0]  vb [8];
   logic [2:0]  vop;
   logic [15:0] res [8];

   // observations of one run
   int          acc_edge [$];
   logic [15:0] od [$];
   logic [2:0]  oi [$];
   logic        ol [$];
   logic [15:0] stall_d [$];
   int          en_count, en_cyc, to_count, to_cyc, first_ov_cyc, last_hs_edge;
   bit          spur_bad;

   function automatic logic [63:0] model_a();
      logic [63:0] v = 64'd0;
      for (int i = 0; i < 8; i++) v = v | (64'(va[i]) << (8 * i));
      return v;
   endfunction

   function automatic logic [63:0] model_b();
      logic [63:0] v = 64'd0;
      for (int i = 0; i < 8; i++) v = v | (64'(vb[i]) << (8 * i));
      return v;
   endfunction

   task automatic random_vector();
      for (int i = 0; i < 8; i++) begin
         va[i]  = 8'($urandom());
         vb[i]  = 8'($urandom());
         res[i] = 16'($urandom());
      end
      vop = 3'($urandom());
   endtask

   // Drives one vector through the block and records what it sees.
   // done_dly < 0: host never answers. spur_t >= 0: done pulse in LOAD at that step.
   // stop_after_en >= 0: return that many cycles after the enable cycle.
   task automatic run_vector(input bit gap, input int done_dly, input int stall_idx,
                             input int stall_len, input int spur_t, input int stop_after_en);
      int sent = 0;
      int got = 0;
      int t = 0;
      int stall_left = stall_len;
      bit fin = 1'b0;
      bit spur_now;
      bit do_done;
      logic [127:0] res_flat;
      acc_edge.delete(); od.delete(); oi.delete(); ol.delete(); stall_d.delete();
      en_count = 0; en_cyc = -1; to_count = 0; to_cyc = -1; first_ov_cyc = -1;
      spur_bad = 1'b0;
      for (int i = 0; i < 8; i++) res_flat[16*i +: 16] = res[i];
      while (!fin && t < 400) begin
         spur_now = (t == spur_t);
         do_done  = spur_now || (en_cyc >= 0 && done_dly >= 0 && cyc == en_cyc + done_dly);
         in_valid = !spur_now && (sent < 8) && (!gap || (t % 2 == 0));
         in_a     = va[sent % 8];
         in_b     = vb[sent % 8];
         in_op    = (sent == 0) ? vop : 3'd5;
         compute_done = do_done;
         vector_result_flat = do_done ? res_flat
                                      : {$urandom(), $urandom(), $urandom(), $urandom()};
         out_ready = !(out_valid && got == stall_idx && stall_left > 0);
         @(negedge clk);
         if (spur_t >= 0 && t == spur_t + 1 &&
             (!in_ready || compute_enable || out_valid || !busy)) spur_bad = 1'b1;
         if (compute_enable) begin en_count++; en_cyc = cyc; end
         if (timeout_err) begin to_count++; to_cyc = cyc; end
         if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
         if (in_valid && in_ready) begin acc_edge.push_back(cyc + 1); sent++; end
         if (out_valid) begin
            if (!out_ready) begin
               stall_d.push_back(out_data);
               stall_left--;
            end else begin
               od.push_back(out_data);
               oi.push_back(out_index);
               ol.push_back(out_last);
               last_hs_edge = cyc + 1;
               got++;
            end
         end
         fin = (got == 8) || (to_count > 0) ||
               (stop_after_en >= 0 && en_cyc >= 0 && cyc == en_cyc + stop_after_en);
         @(posedge clk);
         #1;
         t++;
      end
      compute_done = 1'b0;
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL run_bound: vector did not complete within budget, sent=%0d got=%0d", sent, got);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0; in_op = 3'd0;
      compute_done = 1'b0; vector_result_flat = 128'd0; out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++;
      if ({vector_a_flat, vector_b_flat, vector_op, compute_enable, out_valid, out_data,
           out_index, out_last, busy, timeout_err} !== 164'd0) begin
         errors++;
         $display("FAIL reset_outputs: a=%h b=%h op=%0d en=%b ov=%b od=%h oi=%0d ol=%b busy=%b to=%b want all 0",
                  vector_a_flat, vector_b_flat, vector_op, compute_enable, out_valid, out_data,
                  out_index, out_last, busy, timeout_err);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single_vector();
      for (int i = 0; i < 8; i++) begin
         va[i] = 8'(i + 1);
         vb[i] = 8'((i + 1) * 16);
         res[i] = 16'h1000 + 16'(i);
      end
      vop = 3'd3;
      run_vector(1'b0, 10, -1, 0, -1, -1);
      checks++;
      if (acc_edge.size() != 8) begin errors++; $display("FAIL single_accepts: got %0d want 8", acc_edge.size()); end
      checks++;
      if (vector_a_flat !== 64'h0807060504030201) begin errors++; $display("FAIL single_a_flat: got %h want 0807060504030201", vector_a_flat); end
      checks++;
      if (vector_b_flat !== 64'h8070605040302010) begin errors++; $display("FAIL single_b_flat: got %h want 8070605040302010", vector_b_flat); end
      checks++;
      if (vector_op !== 3'd3) begin errors++; $display("FAIL single_op: got %0d want 3", vector_op); end
      checks++;
      if (en_count != 1) begin errors++; $display("FAIL single_enable_count: got %0d want 1", en_count); end
      checks++;
      if (acc_edge.size() == 8 && en_cyc != acc_edge[7]) begin
         errors++; $display("FAIL single_enable_time: got cycle %0d want %0d", en_cyc, acc_edge[7]);
      end
      checks++;
      if (first_ov_cyc != en_cyc + 11) begin errors++; $display("FAIL single_ov_rise: got %0d want %0d", first_ov_cyc, en_cyc + 11); end
      checks++;
      if (last_hs_edge != first_ov_cyc + 8) begin errors++; $display("FAIL single_drain_rate: got edge %0d want %0d", last_hs_edge, first_ov_cyc + 8); end
      for (int i = 0; i < 8 && i < od.size(); i++) begin
         checks++;
         if (od[i] !== res[i] || oi[i] !== 3'(i) || ol[i] !== (i == 7)) begin
            errors++;
            $display("FAIL single_elem%0d: got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                     i, od[i], oi[i], ol[i], res[i], i, (i == 7));
         end
      end
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL single_return_idle: got in_ready=%b out_valid=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
      end
   endtask

   task automatic test_gapped_backpressure();
      random_vector();
      run_vector(1'b1, 10, 3, 5, -1, -1);
      checks++;
      if (acc_edge.size() != 8) begin errors++; $display("FAIL gap_accepts: got %0d want 8", acc_edge.size()); end
      for (int i = 1; i < acc_edge.size(); i++) begin
         checks++;
         if (acc_edge[i] - acc_edge[i-1] != 2) begin
            errors++; $display("FAIL gap_spacing%0d: got %0d want 2", i, acc_edge[i] - acc_edge[i-1]);
         end
      end
      checks++;
      if (vector_a_flat !== model_a() || vector_b_flat !== model_b() || vector_op !== vop) begin
         errors++; $display("FAIL gap_operands: got a=%h b=%h op=%0d want a=%h b=%h op=%0d",
                            vector_a_flat, vector_b_flat, vector_op, model_a(), model_b(), vop);
      end
      checks++;
      if (stall_d.size() != 5) begin errors++; $display("FAIL gap_stall_len: got %0d want 5", stall_d.size()); end
      foreach (stall_d[i]) begin
         checks++;
         if (stall_d[i] !== res[3]) begin errors++; $display("FAIL gap_stall_hold%0d: got %h want %h", i, stall_d[i], res[3]); end
      end
      checks++;
      if (od.size() != 8) begin errors++; $display("FAIL gap_out_count: got %0d want 8", od.size()); end
      for (int i = 0; i < 8 && i < od.size(); i++) begin
         checks++;
         if (od[i] !== res[i] || oi[i] !== 3'(i)) begin
            errors++; $display("FAIL gap_elem%0d: got %h idx %0d want %h idx %0d", i, od[i], oi[i], res[i], i);
         end
      end
   endtask

   task automatic test_timeout();
      random_vector();
      run_vector(1'b0, -1, -1, 0, -1, -1);
      checks++;
      if (to_count != 1) begin errors++; $display("FAIL timeout_count: got %0d want 1", to_count); end
      checks++;
      if (to_cyc - en_cyc != TO) begin errors++; $display("FAIL timeout_cycle: got WAIT cycle %0d want %0d", to_cyc - en_cyc, TO); end
      checks++;
      if (in_ready !== 1'b1 || timeout_err !== 1'b0) begin
         errors++; $display("FAIL timeout_after: got in_ready=%b timeout_err=%b want 1 0", in_ready, timeout_err);
      end
      checks++;
      if (first_ov_cyc != -1 || od.size() != 0) begin
         errors++; $display("FAIL timeout_no_output: got out_valid first at %0d, %0d elements, want none", first_ov_cyc, od.size());
      end
   endtask

   task automatic test_racing_done();
      random_vector();
      run_vector(1'b0, TO, -1, 0, -1, -1);
      checks++;
      if (to_count != 0) begin errors++; $display("FAIL race_timeout: got %0d pulses want 0", to_count); end
      checks++;
      if (first_ov_cyc != en_cyc + TO + 1) begin errors++; $display("FAIL race_drain: got out_valid at %0d want %0d", first_ov_cyc, en_cyc + TO + 1); end
      checks++;
      if (od.size() != 8) begin errors++; $display("FAIL race_count: got %0d want 8", od.size()); end
      for (int i = 0; i < 8 && i < od.size(); i++) begin
         checks++;
         if (od[i] !== res[i]) begin errors++; $display("FAIL race_elem%0d: got %h want %h", i, od[i], res[i]); end
      end
   endtask

   task automatic test_spurious_done();
      random_vector();
      run_vector(1'b0, 10, -1, 0, 4, -1);
      checks++;
      if (spur_bad) begin errors++; $display("FAIL spur_state: got a reaction to done during LOAD, want none"); end
      checks++;
      if (acc_edge.size() != 8 || en_count != 1) begin
         errors++; $display("FAIL spur_accepts: got %0d accepts %0d enables want 8 1", acc_edge.size(), en_count);
      end
      checks++;
      if (acc_edge.size() == 8 && en_cyc != acc_edge[7]) begin errors++; $display("FAIL spur_enable_time: got %0d want %0d", en_cyc, acc_edge[7]); end
      checks++;
      if (vector_a_flat !== model_a() || vector_b_flat !== model_b()) begin
         errors++; $display("FAIL spur_operands: got a=%h b=%h want a=%h b=%h", vector_a_flat, vector_b_flat, model_a(), model_b());
      end
      for (int i = 0; i < 8 && i < od.size(); i++) begin
         checks++;
         if (od[i] !== res[i]) begin errors++; $display("FAIL spur_elem%0d: got %h want %h", i, od[i], res[i]); end
      end
   endtask

   task automatic test_reset_mid_wait();
      logic [2:0] old_op;
      random_vector();
      run_vector(1'b0, -1, -1, 0, -1, 3);
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || compute_enable !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
         errors++; $display("FAIL rst_mid_flags: got in_ready=%b en=%b busy=%b to=%b want 1 0 0 0", in_ready, compute_enable, busy, timeout_err);
      end
      checks++;
      if ({vector_a_flat, vector_b_flat, vector_op, out_valid, out_data, out_index, out_last} !== 152'd0) begin
         errors++; $display("FAIL rst_mid_data: got a=%h b=%h op=%0d ov=%b od=%h want all 0", vector_a_flat, vector_b_flat, vector_op, out_valid, out_data);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      old_op = vop;
      random_vector();
      vop = old_op + 3'd1;
      run_vector(1'b0, 10, -1, 0, -1, -1);
      checks++;
      if (vector_op !== vop || vector_a_flat !== model_a()) begin
         errors++; $display("FAIL rst_after_operands: got op=%0d a=%h want op=%0d a=%h", vector_op, vector_a_flat, vop, model_a());
      end
      checks++;
      if (od.size() != 8) begin errors++; $display("FAIL rst_after_count: got %0d want 8", od.size()); end
      for (int i = 0; i < 8 && i < od.size(); i++) begin
         checks++;
         if (od[i] !== res[i]) begin errors++; $display("FAIL rst_after_elem%0d: got %h want %h", i, od[i], res[i]); end
      end
   endtask

   task automatic test_back_to_back();
      int prev_edge;
      random_vector();
      run_vector(1'b0, 10, -1, 0, -1, -1);
      for (int i = 0; i < 8 && i < od.size(); i++) begin
         checks++;
         if (od[i] !== res[i]) begin errors++; $display("FAIL b2b_first_elem%0d: got %h want %h", i, od[i], res[i]); end
      end
      prev_edge = last_hs_edge;
      random_vector();
      run_vector(1'b0, 10, -1, 0, -1, -1);
      checks++;
      if (acc_edge.size() == 0 || acc_edge[0] != prev_edge + 1) begin
         errors++; $display("FAIL b2b_first_accept: got edge %0d want %0d", (acc_edge.size() > 0) ? acc_edge[0] : -1, prev_edge + 1);
      end
      checks++;
      if (od.size() != 8) begin errors++; $display("FAIL b2b_second_count: got %0d want 8", od.size()); end
      for (int i = 0; i < 8 && i < od.size(); i++) begin
         checks++;
         if (od[i] !== res[i] || oi[i] !== 3'(i)) begin
            errors++; $display("FAIL b2b_second_elem%0d: got %h idx %0d want %h idx %0d", i, od[i], oi[i], res[i], i);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_vector();
      test_gapped_backpressure();
      test_timeout();
      test_racing_done();
      test_spurious_done();
      test_reset_mid_wait();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vector_stream_driver.md
# vector_stream_driver

Initiator side of the vector compute handshake. The block accepts 8 element pairs (8-bit a, 8-bit b) over a valid/ready stream and packs them into flat 64-bit operand vectors. It then issues a one-cycle `compute_enable` to the vector compute host and waits for `compute_done`. It captures the 128-bit flat result and streams it back out as eight 16-bit elements with valid/ready and a last flag.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: cycles spent in WAIT without `compute_done` before abort. Legal range 16–255.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  input element pair valid.
- `in_ready`  out  1  block accepts element pair.
- `in_a`  in  8  element of vector A.
- `in_b`  in  8  element of vector B.
- `in_op`  in  3  vector operation; sampled with element 0 only.
- `vector_a_flat`  out  64  packed A; element i at bits [8i+7:8i].
- `vector_b_flat`  out  64  packed B; same layout.
- `vector_op`  out  3  operation latched from element 0.
- `compute_enable`  out  1  one-cycle start pulse to the host.
- `compute_done`  in  1  host completion pulse.
- `vector_result_flat`  in  128  host result; element i at bits [16i+15:16i].
- `out_valid`  out  1  result element valid.
- `out_ready`  in  1  downstream accepts element.
- `out_data`  out  16  result element.
- `out_index`  out  3  index of `out_data`.
- `out_last`  out  1  high with index 7.
- `busy`  out  1  high in any state other than LOAD with count 0.
- `timeout_err`  out  1  one-cycle pulse on WAIT abort.

## Operation
- **States:**
  - LOAD: `in_ready`=1. Each `in_valid&in_ready` writes the pair to slot `cnt`. If `cnt`==0, `in_op` is also latched to `vector_op`. `cnt` then increments. On the 8th accept, `cnt` wraps to 0 and the state moves to ISSUE.
  - ISSUE: `compute_enable`=1 for exactly this cycle, then WAIT.
  - WAIT: the watchdog increments each cycle.
    - When `compute_done`=1, latch `vector_result_flat` into the internal result buffer and go to DRAIN.
    - Otherwise, when the watchdog reaches `TIMEOUT_CYCLES`-1, pulse `timeout_err` and go to LOAD. No output is produced for that vector.
  - DRAIN: `out_valid`=1, `out_data`=buffer[16·idx+:16], `out_index`=idx. `idx` advances on `out_valid&out_ready`. After the handshake at idx 7, go to LOAD.
- `vector_a_flat`, `vector_b_flat` and `vector_op` are registers. They stay stable from ISSUE until the next element-0 accept.
- `compute_done` is ignored outside WAIT.
- If `compute_done` and the watchdog terminal count occur in the same cycle, done wins: capture and DRAIN, no `timeout_err`.
- `in_ready`=0 in ISSUE, WAIT and DRAIN. Input is never accepted while a vector is in flight.
- There is no arithmetic. Element widths are fixed (8-bit in, 16-bit out). Counters wrap modulo 8.

## Timing
- **Reset values:**
  - state LOAD, so `in_ready`=1 while `rst` is high.
  - `cnt`, `idx` and the watchdog are 0.
  - `vector_a_flat`, `vector_b_flat`, `vector_op`, `compute_enable`, `out_valid`, `out_data`, `out_index`, `out_last`, `busy` and `timeout_err` are all 0.
- **Input to issue:** the 8th input handshake at edge N puts the block in ISSUE for the cycle after edge N. `compute_enable` is high for that one cycle.
- **Host latency:** the host asserts `compute_done` about 10 cycles after the `compute_enable` cycle. The default timeout leaves margin for this.
- **Result capture:** `compute_done` high at edge M means the result is captured at M. `out_valid` rises in the cycle after M.
- **Drain throughput:** with `out_ready` held high, the 8 elements go out in 8 consecutive cycles. `in_ready` returns in the cycle after the last handshake.
- **Backpressure:** while `out_valid`=1 and `out_ready`=0, `out_data`, `out_index` and `out_last` hold unchanged.
- **Reset mid-operation:** asynchronous clear to the reset values. Any partial vector or buffered result is discarded, and `compute_enable` drops immediately.

## Test plan
- **Single vector:**
  - Stimulus: `in_a`=0x01..0x08, `in_b`=0x10..0x80, `in_op`=3 on element 0 (5 on later elements). The host model returns results 0x1000+i, 10 cycles after issue.
  - Required: `vector_a_flat`=0x0807060504030201, `vector_b_flat`=0x8070605040302010, `vector_op`=3.
  - Required: `compute_enable` is high for exactly one cycle, in the cycle after the 8th accept.
  - Required: the output stream is 0x1000..0x1007 with `out_index` 0..7 and `out_last` only on 0x1007.
- **Gapped input and backpressure:**
  - Stimulus: toggle `in_valid` every other cycle. Then hold `out_ready`=0 for 5 cycles at idx 3.
  - Required: exactly 8 accepts, with `cnt` advancing only on handshakes.
  - Required: `out_data` holds 0x1003 for all 5 stall cycles, and no element is dropped or duplicated.
- **Timeout:**
  - Stimulus: the host model never asserts done, with `TIMEOUT_CYCLES`=64.
  - Required: a `timeout_err` one-cycle pulse in the 64th WAIT cycle.
  - Required: `in_ready`=1 on the next cycle, and `out_valid` never rises.
- **Spurious and racing done:**
  - Stimulus: a `compute_done` pulse during LOAD.
  - Required: the pulse is ignored; state and counters are unchanged.
  - Stimulus: `compute_done` on the watchdog terminal cycle.
  - Required: DRAIN is entered and `timeout_err` stays 0.
- **Reset mid-WAIT:**
  - Stimulus: assert `rst` 4 cycles after issue.
  - Required: all outputs go to their reset values immediately and `in_ready`=1.
  - Required: a following vector completes correctly with fresh `vector_op`.
- **Back-to-back vectors:**
  - Stimulus: two vectors with continuous `in_valid` and `out_ready`.
  - Required: the second vector's first accept occurs in the cycle after the first vector's last output handshake.
  - Required: the results are correct and in order.
